// File: rtl/scoreboard_regfile_decode.sv
// scoreboard_regfile_decode: decode register file with multi-port writeback bypass and a pending-write latency scoreboard; ports: Clk/Rst, ID_* decode slot in, WB_* writeback ports in, ID_rs_val/ID_rt_val/ID_stall/ID_issue/sb_pending out
module scoreboard_regfile_decode #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_WB   = 3,
  parameter int LAT_W    = 3
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     ID_valid,
  input  logic [ADDR_W-1:0]        ID_rs,
  input  logic [ADDR_W-1:0]        ID_rt,
  input  logic [ADDR_W-1:0]        ID_dst,
  input  logic                     ID_RegWrite,
  input  logic [LAT_W-1:0]         ID_lat,
  input  logic [NUM_WB-1:0]        WB_we,
  input  logic [NUM_WB*ADDR_W-1:0] WB_addr,
  input  logic [NUM_WB*DATA_W-1:0] WB_data,
  output logic [DATA_W-1:0]        ID_rs_val,
  output logic [DATA_W-1:0]        ID_rt_val,
  output logic                     ID_stall,
  output logic                     ID_issue,
  output logic [NUM_REGS-1:0]      sb_pending
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [LAT_W-1:0]  cnt  [NUM_REGS];
  logic [LAT_W-1:0]  lat_eff;
  logic              raw_a, raw_b, waw;
  assign lat_eff = (ID_lat == '0) ? LAT_W'(1) : ID_lat;
  always_comb begin
    ID_rs_val = (ID_rs == '0) ? '0 : regs[ID_rs];
    ID_rt_val = (ID_rt == '0) ? '0 : regs[ID_rt];
    for (int k = 0; k < NUM_WB; k++) begin
      if (WB_we[k] && WB_addr[k*ADDR_W +: ADDR_W] == ID_rs && ID_rs != '0) ID_rs_val = WB_data[k*DATA_W +: DATA_W];
      if (WB_we[k] && WB_addr[k*ADDR_W +: ADDR_W] == ID_rt && ID_rt != '0) ID_rt_val = WB_data[k*DATA_W +: DATA_W];
    end
  end
  // cnt==1 means the producer is on a WB port this cycle, so the bypass covers it
  assign raw_a    = ID_rs != '0 && cnt[ID_rs] > LAT_W'(1);
  assign raw_b    = ID_rt != '0 && cnt[ID_rt] > LAT_W'(1);
  assign waw      = ID_RegWrite && ID_dst != '0 && cnt[ID_dst] > lat_eff;
  assign ID_stall = ID_valid && (raw_a || raw_b || waw);
  assign ID_issue = ID_valid && !ID_stall;
  always_comb begin
    sb_pending = '0;
    for (int r = 0; r < NUM_REGS; r++) sb_pending[r] = cnt[r] != '0;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WB; k++)
        if (WB_we[k] && WB_addr[k*ADDR_W +: ADDR_W] != '0)
          regs[WB_addr[k*ADDR_W +: ADDR_W]] <= WB_data[k*DATA_W +: DATA_W];
      for (int r = 1; r < NUM_REGS; r++)
        cnt[r] <= (ID_issue && ID_RegWrite && ID_dst == ADDR_W'(r)) ? lat_eff :
                  (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : cnt[r];
    end
  end
endmodule

// File: tb/tb_scoreboard_regfile_decode.sv
// tb_scoreboard_regfile_decode: directed self-checking bench for scoreboard_regfile_decode
module tb_scoreboard_regfile_decode;
  logic        Clk = 0;
  logic        Rst;
  logic        ID_valid;
  logic [4:0]  ID_rs, ID_rt, ID_dst;
  logic        ID_RegWrite;
  logic [2:0]  ID_lat;
  logic [2:0]  WB_we;
  logic [14:0] WB_addr;
  logic [95:0] WB_data;
  logic [31:0] ID_rs_val, ID_rt_val, sb_pending;
  logic        ID_stall, ID_issue;
  int checks = 0;
  int errors = 0;
  scoreboard_regfile_decode dut (
    .Clk(Clk), .Rst(Rst), .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_dst(ID_dst), .ID_RegWrite(ID_RegWrite), .ID_lat(ID_lat), .WB_we(WB_we),
    .WB_addr(WB_addr), .WB_data(WB_data), .ID_rs_val(ID_rs_val), .ID_rt_val(ID_rt_val),
    .ID_stall(ID_stall), .ID_issue(ID_issue), .sb_pending(sb_pending)
  );
  always #5 Clk = ~Clk;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    ID_valid = 0; ID_rs = 0; ID_rt = 0; ID_dst = 0; ID_RegWrite = 0; ID_lat = 0;
    WB_we = 0; WB_addr = 0; WB_data = 0;
  endtask
  task automatic dec(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                     input logic rw, input logic [2:0] lat);
    ID_valid = 1; ID_rs = rs; ID_rt = rt; ID_dst = dst; ID_RegWrite = rw; ID_lat = lat;
  endtask
  initial begin
    idle();
    Rst = 1;
    tick(); tick();
    Rst = 0;
    // reset state
    dec(5, 0, 0, 0, 0); settle();
    chk("rst_rs_val", ID_rs_val, 0);
    chk("rst_rt_val", ID_rt_val, 0);
    chk("rst_stall", {31'b0, ID_stall}, 0);
    chk("rst_pending", sb_pending, 0);
    chk("rst_issue", {31'b0, ID_issue}, 1);
    tick();
    // RAW with lat=3, resolved by bypass
    dec(0, 0, 8, 1, 3); settle();
    chk("raw_issue", {31'b0, ID_issue}, 1);
    tick();
    dec(8, 0, 0, 0, 0); settle();
    chk("raw_stall_c3", {31'b0, ID_stall}, 1);
    chk("raw_issue_c3", {31'b0, ID_issue}, 0);
    chk("raw_pending", sb_pending, 32'h0000_0100);
    ID_valid = 0; settle();
    chk("raw_novalid_stall", {31'b0, ID_stall}, 0);
    ID_valid = 1;
    tick(); settle();
    chk("raw_stall_c2", {31'b0, ID_stall}, 1);
    tick();
    WB_we = 3'b001; WB_addr = 15'd8; WB_data = 96'hDEADBEEF; settle();
    chk("raw_stall_c1", {31'b0, ID_stall}, 0);
    chk("raw_bypass", ID_rs_val, 32'hDEADBEEF);
    tick();
    WB_we = 0; settle();
    chk("raw_regval", ID_rs_val, 32'hDEADBEEF);
    chk("raw_pending_clear", sb_pending, 0);
    tick();
    // WB port collision: highest port wins; port 1 disabled
    idle();
    ID_rs = 4; ID_rt = 7;
    WB_we = 3'b101;
    WB_addr = {5'd4, 5'd4, 5'd4};
    WB_data = {32'h22, 32'h33, 32'h11}; settle();
    chk("coll_bypass", ID_rs_val, 32'h22);
    chk("coll_rt_noreg", ID_rt_val, 0);
    chk("coll_novalid_issue", {31'b0, ID_issue}, 0);
    tick();
    WB_we = 3'b010; WB_addr = {5'd0, 5'd7, 5'd0}; WB_data = {32'h0, 32'h77, 32'h0}; settle();
    chk("coll_reg4", ID_rs_val, 32'h22);
    chk("p1_bypass", ID_rt_val, 32'h77);
    tick();
    idle(); ID_rt = 7; settle();
    chk("p1_reg7", ID_rt_val, 32'h77);
    // WAW stall then reload
    dec(0, 0, 6, 1, 4); settle();
    chk("waw_first_issue", {31'b0, ID_issue}, 1);
    tick();
    dec(0, 0, 6, 1, 1); settle();
    chk("waw_stall_c4", {31'b0, ID_stall}, 1);
    tick(); settle();
    chk("waw_stall_c3", {31'b0, ID_stall}, 1);
    tick(); settle();
    chk("waw_stall_c2", {31'b0, ID_stall}, 1);
    tick(); settle();
    chk("waw_issue_c1", {31'b0, ID_issue}, 1);
    tick();
    dec(6, 0, 0, 0, 0); settle();
    chk("waw_reload_pending", sb_pending, 32'h0000_0040);
    chk("waw_cnt1_nostall", {31'b0, ID_stall}, 0);
    tick(); settle();
    chk("waw_pending_done", sb_pending, 0);
    // reset mid-operation
    dec(0, 0, 9, 1, 3); settle();
    tick();
    idle(); Rst = 1;
    tick();
    Rst = 0;
    dec(9, 8, 0, 0, 0); settle();
    chk("rst2_stall", {31'b0, ID_stall}, 0);
    chk("rst2_pending", sb_pending, 0);
    chk("rst2_rs_val", ID_rs_val, 0);
    chk("rst2_rt_val", ID_rt_val, 0);
    tick();
    // dst=0 never tracked; lat=0 behaves as lat=1
    dec(0, 0, 0, 1, 0); settle();
    chk("dst0_issue", {31'b0, ID_issue}, 1);
    tick();
    dec(0, 0, 0, 0, 0); settle();
    chk("dst0_pending", sb_pending, 0);
    tick();
    dec(0, 0, 3, 1, 0); settle();
    chk("lat0_issue", {31'b0, ID_issue}, 1);
    tick();
    dec(3, 0, 3, 1, 0); settle();
    chk("lat0_pending", sb_pending, 32'h0000_0008);
    chk("lat0_nostall", {31'b0, ID_stall}, 0);
    tick();
    idle(); settle();
    chk("lat0_reload", sb_pending, 32'h0000_0008);
    tick(); settle();
    chk("lat0_clear", sb_pending, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
